// File: rtl/uart_param_pkg.sv
// Shared types and helpers for the parametrised UART: FSM state enums, parity
// calculation and parameter legality checks.
package uart_param_pkg;

  typedef enum logic [2:0] {
    StTxIdle,
    StTxStart,
    StTxData,
    StTxParity,
    StTxStop,
    StTxDone
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    StRxIdle,
    StRxStart,
    StRxData,
    StRxParity,
    StRxStop,
    StRxDone
  } uart_rx_state_t;

  localparam int unsigned MinDataBits = 5;
  localparam int unsigned MaxDataBits = 9;

  // Callers zero-extend narrower payloads; zeros do not change the XOR.
  function automatic logic calc_parity(input logic [MaxDataBits-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic bit data_bits_legal(input int unsigned n);
    return (n >= MinDataBits) && (n <= MaxDataBits);
  endfunction

  function automatic bit stop_bits_legal(input int unsigned n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_param_if.sv
// Client/pin-side signal bundle of uart_param. The slave modport is the UART
// itself; the master modport is the client plus the serial line.
interface uart_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 parity_odd;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid, parity_odd, rx,
    input  tx_ready, tx, tx_busy, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid, parity_odd, rx,
    output tx_ready, tx, tx_busy, tx_done, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..DIV-1 and restarts, flags the mid-point
// ((DIV-1)/2) and the last count (DIV-1). clear holds it at zero.
module uart_bit_timer #(
  parameter int unsigned DIV   = 10,
  parameter int unsigned DIV_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  logic [DIV_W-1:0] cnt_q;

  assign half_tick = (cnt_q == DIV_W'((DIV - 1) / 2));
  assign full_tick = (cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || full_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with valid/ready TX and strobed RX plus error flags.
// Define UART_PARITY_EN to add a parity bit in both directions.
module uart_param
  import uart_param_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 19200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input logic         clk,
  input logic         rst,
  uart_param_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned IDX_W = 4;

  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_param: DATA_BITS must be within 5..9");
  end
  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_param: STOP_BITS must be 1 or 2");
  end
  if (DIV < 4) begin : g_bad_div
    $error("uart_param: CLK_FREQ/BAUD_RATE must be at least 4");
  end

`ifdef UART_PARITY_EN
  localparam uart_tx_state_t TxAfterData = StTxParity;
  localparam uart_rx_state_t RxAfterData = StRxParity;
`else
  localparam uart_tx_state_t TxAfterData = StTxStop;
  localparam uart_rx_state_t RxAfterData = StRxStop;
  logic unused_parity_odd;
  assign unused_parity_odd = bus.parity_odd;
`endif

  // ---------------- transmitter ----------------
  uart_tx_state_t       tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_line, tx_clear, tx_full, unused_tx_half;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_clear = (tx_state_q == StTxIdle) || (tx_state_q == StTxDone);

  uart_bit_timer #(.DIV(DIV), .DIV_W(DIV_W)) u_tx_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tx_clear),
    .half_tick (unused_tx_half),
    .full_tick (tx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StTxIdle;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_stop_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_stop_q  <= tx_stop_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_stop_d  = tx_stop_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_line    = 1'b1;
    case (tx_state_q)
      StTxIdle: begin
        if (bus.tx_valid) begin
          tx_state_d = StTxStart;
          tx_shift_d = bus.tx_data;
          tx_idx_d   = '0;
          tx_stop_d  = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = calc_parity(MaxDataBits'(bus.tx_data), bus.parity_odd);
`endif
        end
      end
      StTxStart: begin
        tx_line = 1'b0;
        if (tx_full) tx_state_d = StTxData;
      end
      StTxData: begin
        tx_line = tx_shift_q[0];
        if (tx_full) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == IDX_W'(DATA_BITS - 1)) tx_state_d = TxAfterData;
          else tx_idx_d = tx_idx_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      StTxParity: begin
        tx_line = tx_par_q;
        if (tx_full) tx_state_d = StTxStop;
      end
`endif
      StTxStop: begin
        if (tx_full) begin
          if (tx_stop_q == 1'(STOP_BITS - 1)) tx_state_d = StTxDone;
          else tx_stop_d = 1'b1;
        end
      end
      StTxDone: tx_state_d = StTxIdle;
      default:  tx_state_d = StTxIdle;
    endcase
  end

  assign bus.tx       = tx_line;
  assign bus.tx_ready = (tx_state_q == StTxIdle);
  assign bus.tx_busy  = (tx_state_q != StTxIdle);
  assign bus.tx_done  = (tx_state_q == StTxDone);

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  uart_rx_state_t       rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                 rx_stop_q, rx_stop_d, rx_ferr_q, rx_ferr_d;
  logic                 rx_ferr_out_q, rx_ferr_out_d;
  logic                 rx_clear, rx_half, rx_full;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
`endif

  assign rx_s     = rx_sync_q[1];
  // Restart the timer at the start-bit midpoint so data samples land mid-bit.
  assign rx_clear = (rx_state_q == StRxIdle) || ((rx_state_q == StRxStart) && rx_half);

  uart_bit_timer #(.DIV(DIV), .DIV_W(DIV_W)) u_rx_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (rx_clear),
    .half_tick (rx_half),
    .full_tick (rx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q     <= 2'b11;
      rx_state_q    <= StRxIdle;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_idx_q      <= '0;
      rx_stop_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_ferr_out_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q      <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
`endif
    end else begin
      rx_sync_q     <= {rx_sync_q[0], bus.rx};
      rx_state_q    <= rx_state_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_idx_q      <= rx_idx_d;
      rx_stop_q     <= rx_stop_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_ferr_out_q <= rx_ferr_out_d;
`ifdef UART_PARITY_EN
      rx_par_q      <= rx_par_d;
      rx_odd_q      <= rx_odd_d;
      rx_perr_q     <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_idx_d      = rx_idx_q;
    rx_stop_d     = rx_stop_q;
    rx_ferr_d     = rx_ferr_q;
    rx_ferr_out_d = rx_ferr_out_q;
`ifdef UART_PARITY_EN
    rx_par_d      = rx_par_q;
    rx_odd_d      = rx_odd_q;
    rx_perr_d     = rx_perr_q;
`endif
    case (rx_state_q)
      StRxIdle: begin
        if (!rx_s) begin
          rx_state_d = StRxStart;
`ifdef UART_PARITY_EN
          rx_odd_d   = bus.parity_odd;
`endif
        end
      end
      StRxStart: begin
        if (rx_half) begin
          if (rx_s) begin
            rx_state_d = StRxIdle;
          end else begin
            rx_state_d = StRxData;
            rx_idx_d   = '0;
            rx_stop_d  = 1'b0;
            rx_ferr_d  = 1'b0;
          end
        end
      end
      StRxData: begin
        if (rx_full) begin
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == IDX_W'(DATA_BITS - 1)) rx_state_d = RxAfterData;
          else rx_idx_d = rx_idx_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      StRxParity: begin
        if (rx_full) begin
          rx_par_d   = rx_s;
          rx_state_d = StRxStop;
        end
      end
`endif
      StRxStop: begin
        if (rx_full) begin
          rx_ferr_d = rx_ferr_q | ~rx_s;
          if (rx_stop_q == 1'(STOP_BITS - 1)) begin
            rx_state_d    = StRxDone;
            rx_data_d     = rx_shift_q;
            rx_ferr_out_d = rx_ferr_q | ~rx_s;
`ifdef UART_PARITY_EN
            rx_perr_d     = rx_par_q ^ calc_parity(MaxDataBits'(rx_shift_q), rx_odd_q);
`endif
          end else begin
            rx_stop_d = 1'b1;
          end
        end
      end
      StRxDone: rx_state_d = StRxIdle;
      default:  rx_state_d = StRxIdle;
    endcase
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = (rx_state_q == StRxDone);
  assign bus.rx_frame_err = rx_ferr_out_q;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = rx_perr_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: an 8N1 instance (loopback or driven RX)
// and a 5-data/2-stop instance in loopback; RX frames checked via a scoreboard.
`timescale 1ns/1ps
module tb_uart_param;
  import uart_param_pkg::*;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS8 = 1 + 8 + P + 1;
  localparam int unsigned FRAME5 = (1 + 5 + P + 2) * DIV;

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } rx_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop8 = 1'b1;
  logic rx_drv8 = 1'b1;
  int   cyc = 0;
  int   done8_cnt = 0;
  int   passed = 0;
  int   total = 0;
  rx_rec_t obs8[$], exp8[$], obs5[$], exp5[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_param_if #(.DATA_BITS(8)) bus8 ();
  uart_param_if #(.DATA_BITS(5)) bus5 ();

  assign bus8.rx = loop8 ? bus8.tx : rx_drv8;
  assign bus5.rx = bus5.tx;

  uart_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  uart_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(5), .STOP_BITS(2)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  always @(negedge clk) begin
    if (bus8.rx_valid) obs8.push_back({1'b0, bus8.rx_data, bus8.rx_frame_err, bus8.rx_parity_err});
    if (bus5.rx_valid) obs5.push_back({4'b0, bus5.rx_data, bus5.rx_frame_err, bus5.rx_parity_err});
    if (bus8.tx_done) done8_cnt <= done8_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Drives n bits of v (LSB first) onto the 8-bit instance's RX pin, then idles high.
  task automatic drive_bits(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv8 = v[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv8 = 1'b1;
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus8.tx, bus8.tx_ready, bus8.tx_busy, bus8.tx_done} !== 4'b1100)
      $display("FAIL reset_tx8: tx/ready/busy/done=%b want 1100",
               {bus8.tx, bus8.tx_ready, bus8.tx_busy, bus8.tx_done});
    else passed++;
    total++;
    if ({bus8.rx_data, bus8.rx_valid, bus8.rx_frame_err, bus8.rx_parity_err} !== 11'h0)
      $display("FAIL reset_rx8: data/valid/ferr/perr=%h want 0",
               {bus8.rx_data, bus8.rx_valid, bus8.rx_frame_err, bus8.rx_parity_err});
    else passed++;
    total++;
    if ({bus5.tx, bus5.tx_ready, bus5.tx_busy, bus5.tx_done, bus5.rx_data, bus5.rx_valid}
        !== {4'b1100, 6'h0})
      $display("FAIL reset_5: tx/ready/busy/done/rx_data/valid=%b want 1100000000",
               {bus5.tx, bus5.tx_ready, bus5.tx_busy, bus5.tx_done, bus5.rx_data, bus5.rx_valid});
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends one byte on the 8-bit instance and checks the waveform cycle by cycle.
  task automatic send8(input string name, input logic [7:0] d, input logic odd);
    logic bits[$];
    logic bad, got;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_PARITY_EN
    bits.push_back((^d) ^ odd);
`endif
    bits.push_back(1'b1);
    @(negedge clk);
    bus8.tx_data    = d;
    bus8.parity_odd = odd;
    bus8.tx_valid   = 1'b1;
    exp8.push_back({1'b0, d, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus8.tx_valid = 1'b0;
    bus8.tx_data  = ~d;
    for (int b = 0; b < bits.size(); b++) begin
      bad = 1'b0;
      got = bits[b];
      for (int c = 0; c < int'(DIV); c++) begin
        if (!bad && (bus8.tx !== bits[b] || bus8.tx_done !== 1'b0 || bus8.tx_ready !== 1'b0)) begin
          bad = 1'b1;
          got = bus8.tx;
        end
        @(negedge clk);
      end
      total++;
      if (bad)
        $display("FAIL %s_bit%0d: tx=%b (or done/ready high) want tx=%b done=0 ready=0",
                 name, b, got, bits[b]);
      else passed++;
    end
    total++;
    if (bus8.tx_done !== 1'b1 || bus8.tx_ready !== 1'b0)
      $display("FAIL %s_done: tx_done=%b tx_ready=%b want 1 0 at %0d clocks",
               name, bus8.tx_done, bus8.tx_ready, NBITS8 * DIV + 1);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus8.tx_ready, bus8.tx_done, bus8.tx_busy} !== 3'b100)
      $display("FAIL %s_idle: ready/done/busy=%b want 100", name,
               {bus8.tx_ready, bus8.tx_done, bus8.tx_busy});
    else passed++;
  endtask

  task automatic test_loopback_a5();
    rx_rec_t e, o;
    loop8 = 1'b1;
    send8("a5", 8'hA5, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if (obs8.size() == 0 || exp8.size() == 0) begin
      $display("FAIL a5_rx: %0d strobes seen want 1", obs8.size());
    end else begin
      e = exp8.pop_front();
      o = obs8.pop_front();
      if (o !== e) $display("FAIL a5_rx: got %h want %h", o, e);
      else passed++;
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    rx_rec_t e, o;
    logic [7:0] d;
    loop8 = 1'b1;
    send8("par03", 8'h03, 1'b1);
    repeat (5) @(negedge clk);
    total++;
    if (obs8.size() == 0 || exp8.size() == 0) begin
      $display("FAIL par03_rx: %0d strobes seen want 1", obs8.size());
    end else begin
      e = exp8.pop_front();
      o = obs8.pop_front();
      if (o !== e) $display("FAIL par03_rx: got %h want %h", o, e);
      else passed++;
    end
    loop8 = 1'b0;
    d = 8'h3C;
    exp8.push_back({1'b0, d, 1'b0, 1'b1});
    drive_bits({2'b11, 1'b1, ~((^d) ^ bus8.parity_odd), d, 1'b0}, NBITS8);
    total++;
    if (obs8.size() == 0 || exp8.size() == 0) begin
      $display("FAIL par_flip_rx: %0d strobes seen want 1", obs8.size());
    end else begin
      e = exp8.pop_front();
      o = obs8.pop_front();
      if (o !== e) $display("FAIL par_flip_rx: got %h want %h", o, e);
      else passed++;
    end
    loop8 = 1'b1;
  endtask
`endif

  task automatic test_frame_err();
    rx_rec_t e, o;
    logic [7:0]  d;
    logic [11:0] v;
    loop8 = 1'b0;
    d = 8'h5C;
`ifdef UART_PARITY_EN
    v = {2'b11, 1'b0, (^d) ^ bus8.parity_odd, d, 1'b0};
`else
    v = {3'b111, 1'b0, d, 1'b0};
`endif
    exp8.push_back({1'b0, d, 1'b1, 1'b0});
    drive_bits(v, NBITS8);
    total++;
    if (obs8.size() == 0 || exp8.size() == 0) begin
      $display("FAIL ferr_rx: %0d strobes seen want 1", obs8.size());
    end else begin
      e = exp8.pop_front();
      o = obs8.pop_front();
      if (o !== e) $display("FAIL ferr_rx: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    loop8   = 1'b0;
    rx_drv8 = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv8 = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    total++;
    if (obs8.size() != 0) $display("FAIL glitch_strobe: %0d strobes want 0", obs8.size());
    else passed++;
    total++;
    if (dut8.rx_state_q !== StRxIdle)
      $display("FAIL glitch_idle: rx state %0d want %0d", dut8.rx_state_q, StRxIdle);
    else passed++;
    loop8 = 1'b1;
  endtask

  task automatic test_back_to_back();
    rx_rec_t e, o;
    int hs[$];
    @(negedge clk);
    bus5.tx_data    = 5'h1B;
    bus5.parity_odd = 1'b0;
    bus5.tx_valid   = 1'b1;
    for (int c = 0; c < 400 && hs.size() < 3; c++) begin
      if (bus5.tx_ready) begin
        hs.push_back(cyc);
        exp5.push_back({4'b0, 5'h1B, 2'b00});
      end
      @(negedge clk);
    end
    bus5.tx_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      total++;
      if (hs.size() < 3) $display("FAIL b2b_hs%0d: %0d handshakes want 3", i, hs.size());
      else if (hs[i] - hs[i-1] != int'(FRAME5 + 2))
        $display("FAIL b2b_hs%0d: spacing %0d want %0d", i, hs[i] - hs[i-1], FRAME5 + 2);
      else passed++;
    end
    for (int c = 0; c < 400 && obs5.size() < 3; c++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs5.size() == 0 || exp5.size() == 0) begin
        $display("FAIL b2b_rx%0d: no strobe, want data 1b", i);
      end else begin
        e = exp5.pop_front();
        o = obs5.pop_front();
        if (o !== e) $display("FAIL b2b_rx%0d: got %h want %h", i, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, o0;
    loop8 = 1'b1;
    @(negedge clk);
    bus8.tx_data  = 8'hC3;
    bus8.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.tx_valid = 1'b0;
    repeat (25) @(negedge clk);
    d0  = done8_cnt;
    o0  = obs8.size();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus8.tx, bus8.tx_ready} !== 2'b11)
      $display("FAIL rst_mid_tx: tx/ready=%b want 11", {bus8.tx, bus8.tx_ready});
    else passed++;
    rst = 1'b0;
    repeat (15 * DIV) @(negedge clk);
    total++;
    if (done8_cnt != d0) $display("FAIL rst_mid_done: %0d tx_done pulses want 0", done8_cnt - d0);
    else passed++;
    total++;
    if (obs8.size() != o0) $display("FAIL rst_mid_rx: %0d strobes want 0", obs8.size() - o0);
    else passed++;
  endtask

  initial begin
    bus8.tx_data = '0; bus8.tx_valid = 1'b0; bus8.parity_odd = 1'b0;
    bus5.tx_data = '0; bus5.tx_valid = 1'b0; bus5.parity_odd = 1'b0;
    test_reset();
    test_loopback_a5();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    total++;
    if (exp8.size() + obs8.size() + exp5.size() + obs5.size() != 0)
      $display("FAIL leftover: exp8=%0d obs8=%0d exp5=%0d obs5=%0d want all 0",
               exp8.size(), obs8.size(), exp5.size(), obs5.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
